// File: rtl/audio_ctrl_pkg.sv
// Shared encodings for the audio stream controller: source modes, FSM states, sample width.
package audio_ctrl_pkg;

  localparam int SAMPLE_W = 24;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_ROM  = 2'b01;
  localparam logic [1:0] MODE_MUTE = 2'b10;
  localparam logic [1:0] MODE_MIX  = 2'b11;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CAPTURE    = 3'd1;
  localparam logic [2:0] ST_ROM_WAIT   = 3'd2;
  localparam logic [2:0] ST_COMPUTE    = 3'd3;
  localparam logic [2:0] ST_WRITE_WAIT = 3'd4;
  localparam logic [2:0] ST_PUSH       = 3'd5;

  // Modes that read the tone ROM and therefore advance its address.
  function automatic logic uses_rom(input logic [1:0] m);
    return (m == MODE_ROM) || (m == MODE_MIX);
  endfunction

endpackage

// File: rtl/audio_stream_ctrl_if.sv
// Codec sample handshake bundle: ADC pop side and DAC push side.
interface audio_stream_ctrl_if #(
  parameter int SAMPLE_W = audio_ctrl_pkg::SAMPLE_W
);
  logic                read_ready;
  logic                write_ready;
  logic [SAMPLE_W-1:0] readdata_left;
  logic [SAMPLE_W-1:0] readdata_right;
  logic                read;
  logic                write;
  logic [SAMPLE_W-1:0] writedata_left;
  logic [SAMPLE_W-1:0] writedata_right;

  modport master (
    input  read_ready, write_ready, readdata_left, readdata_right,
    output read, write, writedata_left, writedata_right
  );

  modport slave (
    output read_ready, write_ready, readdata_left, readdata_right,
    input  read, write, writedata_left, writedata_right
  );
endinterface

// File: rtl/audio_sample_mixer.sv
// One channel of source select, line-in/ROM averaging and sign-preserving attenuation.
module audio_sample_mixer #(
  parameter int SAMPLE_W = 24
) (
  input  logic [1:0]          mode,
  input  logic [2:0]          atten,
  input  logic [SAMPLE_W-1:0] in_sample,
  input  logic [SAMPLE_W-1:0] rom_sample,
  output logic [SAMPLE_W-1:0] out_sample
);
  import audio_ctrl_pkg::*;

  logic [SAMPLE_W:0]          sum;
  logic signed [SAMPLE_W-1:0] src;

  // One guard bit makes the average exact; halving always fits back in SAMPLE_W.
  always_comb begin
    sum = {in_sample[SAMPLE_W-1], in_sample} + {rom_sample[SAMPLE_W-1], rom_sample};
  end

  always_comb begin
    src = in_sample;
    case (mode)
      MODE_PASS: src = in_sample;
      MODE_ROM:  src = rom_sample;
      MODE_MUTE: src = {SAMPLE_W{1'b0}};
      MODE_MIX:  src = SAMPLE_W'(sum >> 1);
      default:   src = {SAMPLE_W{1'b0}};
    endcase
  end

  always_comb begin
    out_sample = src >>> atten;
  end

endmodule

// File: rtl/audio_stream_ctrl.sv
// Per-sample sequencer between the audio codec and the tone ROM: pops one ADC sample,
// forms the DAC sample from the latched mode, pushes it, and advances the ROM address.
module audio_stream_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int ROM_DEPTH = 65536,
  parameter int ROM_LAT   = 2,
  parameter int SAMPLE_W  = 24
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  input  logic                loop_en,
  input  logic [2:0]          atten,
  audio_stream_ctrl_if.master codec,
  input  logic [SAMPLE_W-1:0] rom_q,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                rom_done,
  output logic                busy,
  output logic [15:0]         stall_cnt
);
  import audio_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(ROM_LAT - 1);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [1:0]          mode_q;
  logic                loop_q;
  logic [2:0]          atten_q;
  logic [1:0]          wait_cnt;
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;
  logic [SAMPLE_W-1:0] rom_eff;
  logic [SAMPLE_W-1:0] mix_left;
  logic [SAMPLE_W-1:0] mix_right;
  logic                start;

  always_comb begin
    start = (state == ST_IDLE) && codec.read_ready;
  end

  // Next-state logic; read_ready outside IDLE is simply left in the codec FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (codec.read_ready) state_nxt = ST_CAPTURE;
        else                  state_nxt = ST_IDLE;
      end
      ST_CAPTURE:  state_nxt = ST_ROM_WAIT;
      ST_ROM_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = ST_COMPUTE;
        else                       state_nxt = ST_ROM_WAIT;
      end
      ST_COMPUTE:  state_nxt = ST_WRITE_WAIT;
      ST_WRITE_WAIT: begin
        if (codec.write_ready) state_nxt = ST_PUSH;
        else                   state_nxt = ST_WRITE_WAIT;
      end
      ST_PUSH:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Strobes and busy are decoded from the next state so they are registered yet aligned.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      codec.read  <= 1'b0;
      codec.write <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != ST_IDLE);
      codec.read  <= (state_nxt == ST_CAPTURE);
      codec.write <= (state_nxt == ST_PUSH);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= 2'b00;
      loop_q   <= 1'b0;
      atten_q  <= 3'd0;
      wait_cnt <= 2'd0;
      in_left  <= {SAMPLE_W{1'b0}};
      in_right <= {SAMPLE_W{1'b0}};
    end else begin
      if (start) begin
        mode_q  <= mode;
        loop_q  <= loop_en;
        atten_q <= atten;
      end
      if (state == ST_CAPTURE) begin
        in_left  <= codec.readdata_left;
        in_right <= codec.readdata_right;
      end
      if (state == ST_ROM_WAIT) wait_cnt <= wait_cnt + 2'd1;
      else                      wait_cnt <= 2'd0;
    end
  end

  // A finished non-looping tone contributes silence.
  always_comb begin
    if (rom_done) rom_eff = {SAMPLE_W{1'b0}};
    else          rom_eff = rom_q;
  end

  audio_sample_mixer #(.SAMPLE_W(SAMPLE_W)) u_mix_left (
    .mode       (mode_q),
    .atten      (atten_q),
    .in_sample  (in_left),
    .rom_sample (rom_eff),
    .out_sample (mix_left)
  );

  audio_sample_mixer #(.SAMPLE_W(SAMPLE_W)) u_mix_right (
    .mode       (mode_q),
    .atten      (atten_q),
    .in_sample  (in_right),
    .rom_sample (rom_eff),
    .out_sample (mix_right)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      codec.writedata_left  <= {SAMPLE_W{1'b0}};
      codec.writedata_right <= {SAMPLE_W{1'b0}};
    end else if (state == ST_COMPUTE) begin
      codec.writedata_left  <= mix_left;
      codec.writedata_right <= mix_right;
    end
  end

  // Address only moves once the sample has been pushed; non-ROM modes rewind the tone.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= {ADDR_W{1'b0}};
      rom_done <= 1'b0;
    end else if (start && !uses_rom(mode)) begin
      rom_addr <= {ADDR_W{1'b0}};
      rom_done <= 1'b0;
    end else if ((state == ST_PUSH) && uses_rom(mode_q) && !rom_done) begin
      if (rom_addr < LAST_ADDR) rom_addr <= rom_addr + ADDR_W'(1);
      else if (loop_q)          rom_addr <= {ADDR_W{1'b0}};
      else                      rom_done <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 16'd0;
    end else if ((state == ST_WRITE_WAIT) && !codec.write_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
